// File: rtl/hole_hit_detector.sv
// hole_hit_detector
// Watches per-pixel ball/hole draw requests, confirms a ball-in-hole overlap
// over CONFIRM_FRAMES consecutive frames and emits one single-cycle hit pulse
// per ball per sinking. Rearms when the ball is hidden or the rack restarts.
// Optional build macro HOLE_HIT_COUNT_EN adds saturating 8-bit hit counters
// (whiteHitCount, redHitCount), cleared only by reset.
module hole_hit_detector #(
  parameter int HOLE_COUNT     = 6,
  parameter int CONFIRM_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       whiteBallDR,
  input  logic       redBallDR,
  input  logic       holeDR,
  input  logic [2:0] holeIdx,
  input  logic       whiteBallShow,
  input  logic       redBallShow,
  input  logic       resetGameN,
  output logic       whiteBallHoleHit,
  output logic       redBallHoleHit,
  output logic [2:0] redBallHoleNum
`ifdef HOLE_HIT_COUNT_EN
  ,
  output logic [7:0] whiteHitCount,
  output logic [7:0] redHitCount
`endif
);

  typedef enum logic [1:0] {
    ARMED,
    COUNTING,
    FIRE,
    FIRED
  } state_e;

  localparam logic [3:0] CONFIRM_CNT = 4'(CONFIRM_FRAMES);
  localparam logic [3:0] HOLE_MAX    = 4'(HOLE_COUNT);

  logic       idx_valid;
  logic       white_ov;
  logic       red_ov;
  logic       white_seen_q, white_seen_d;
  logic       red_seen_q, red_seen_d;
  logic [2:0] red_idx_q, red_idx_d;

  state_e     white_state_q;
  logic [3:0] white_cnt_q;
  logic       white_hit_q;

  state_e     red_state_q;
  logic [3:0] red_cnt_q;
  logic [2:0] red_hold_idx_q;
  logic       red_hit_q;
  logic [2:0] red_num_q;

  // Holes 1..HOLE_COUNT are real; index 0 and out-of-range values never count.
  assign idx_valid = holeDR && (holeIdx != 3'd0) && ({1'b0, holeIdx} <= HOLE_MAX);
  assign white_ov  = whiteBallDR && idx_valid && whiteBallShow;
  assign red_ov    = redBallDR && idx_valid && redBallShow;

  // Per-frame overlap accumulator; a startOfFrame-cycle pixel opens the new frame.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    white_seen_d = white_seen_q;
    red_seen_d   = red_seen_q;
    red_idx_d    = red_idx_q;
    if (startOfFrame) begin
      white_seen_d = white_ov;
      red_seen_d   = red_ov;
      red_idx_d    = red_ov ? holeIdx : 3'd0;
    end else begin
      if (white_ov) white_seen_d = 1'b1;
      if (red_ov && !red_seen_q) begin
        red_seen_d = 1'b1;
        red_idx_d  = holeIdx;
      end
    end
    // A hidden ball must never contribute to a confirmation.
    if (!whiteBallShow) white_seen_d = 1'b0;
    if (!redBallShow) begin
      red_seen_d = 1'b0;
      red_idx_d  = 3'd0;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      white_seen_q <= 1'b0;
      red_seen_q   <= 1'b0;
      red_idx_q    <= 3'd0;
    end else begin
      white_seen_q <= white_seen_d;
      red_seen_q   <= red_seen_d;
      red_idx_q    <= red_idx_d;
    end
  end

  // White ball confirm FSM; flags of the finished frame are judged at startOfFrame.
  always_ff @(posedge clk) begin
    if (reset) begin
      white_state_q <= ARMED;
      white_cnt_q   <= 4'd0;
      white_hit_q   <= 1'b0;
    end else begin
      white_hit_q <= 1'b0;
      if (!resetGameN || !whiteBallShow) begin
        white_state_q <= ARMED;
        white_cnt_q   <= 4'd0;
      end else begin
        case (white_state_q)
          ARMED: begin
            if (startOfFrame && white_seen_q) begin
              white_cnt_q <= 4'd1;
              if (CONFIRM_CNT == 4'd1) begin
                white_state_q <= FIRE;
                white_hit_q   <= 1'b1;
              end else begin
                white_state_q <= COUNTING;
              end
            end
          end
          COUNTING: begin
            if (startOfFrame) begin
              if (!white_seen_q) begin
                white_state_q <= ARMED;
                white_cnt_q   <= 4'd0;
              end else begin
                white_cnt_q <= white_cnt_q + 4'd1;
                if (white_cnt_q + 4'd1 >= CONFIRM_CNT) begin
                  white_state_q <= FIRE;
                  white_hit_q   <= 1'b1;
                end
              end
            end
          end
          FIRE:    white_state_q <= FIRED;
          FIRED:   white_state_q <= FIRED;
          default: white_state_q <= ARMED;
        endcase
      end
    end
  end

  // Red ball confirm FSM; a change of hole while counting restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      red_state_q    <= ARMED;
      red_cnt_q      <= 4'd0;
      red_hold_idx_q <= 3'd0;
      red_hit_q      <= 1'b0;
      red_num_q      <= 3'd0;
    end else begin
      red_hit_q <= 1'b0;
      if (!resetGameN || !redBallShow) begin
        red_state_q <= ARMED;
        red_cnt_q   <= 4'd0;
      end else begin
        case (red_state_q)
          ARMED: begin
            if (startOfFrame && red_seen_q) begin
              red_cnt_q      <= 4'd1;
              red_hold_idx_q <= red_idx_q;
              if (CONFIRM_CNT == 4'd1) begin
                red_state_q <= FIRE;
                red_hit_q   <= 1'b1;
                red_num_q   <= red_idx_q;
              end else begin
                red_state_q <= COUNTING;
              end
            end
          end
          COUNTING: begin
            if (startOfFrame) begin
              if (!red_seen_q) begin
                red_state_q <= ARMED;
                red_cnt_q   <= 4'd0;
              end else if (red_idx_q != red_hold_idx_q) begin
                red_cnt_q      <= 4'd1;
                red_hold_idx_q <= red_idx_q;
              end else begin
                red_cnt_q <= red_cnt_q + 4'd1;
                if (red_cnt_q + 4'd1 >= CONFIRM_CNT) begin
                  red_state_q <= FIRE;
                  red_hit_q   <= 1'b1;
                  red_num_q   <= red_idx_q;
                end
              end
            end
          end
          FIRE:    red_state_q <= FIRED;
          FIRED:   red_state_q <= FIRED;
          default: red_state_q <= ARMED;
        endcase
      end
    end
  end

  assign whiteBallHoleHit = white_hit_q;
  assign redBallHoleHit   = red_hit_q;
  assign redBallHoleNum   = red_num_q;

`ifdef HOLE_HIT_COUNT_EN
  logic [7:0] white_count_q;
  logic [7:0] red_count_q;

  // Saturating hit counters, bumped at the end of each FIRE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      white_count_q <= 8'd0;
      red_count_q   <= 8'd0;
    end else begin
      if (white_hit_q && (white_count_q != 8'hFF)) white_count_q <= white_count_q + 8'd1;
      if (red_hit_q && (red_count_q != 8'hFF)) red_count_q <= red_count_q + 8'd1;
    end
  end

  assign whiteHitCount = white_count_q;
  assign redHitCount   = red_count_q;
`endif

endmodule

// File: tb/tb_hole_hit_detector.sv
// Self-checking bench for hole_hit_detector (HOLE_COUNT=6, CONFIRM_FRAMES=2).
// Each frame is 8 cycles: startOfFrame in cycle 0, ball/hole pixels in cycles
// 2..5 (or only in cycle 0 for the frame-boundary case). The expected outcome
// of every startOfFrame evaluation is queued when the frame is driven and
// compared in the cycle after that startOfFrame.
module tb_hole_hit_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic       whiteBallDR;
  logic       redBallDR;
  logic       holeDR;
  logic [2:0] holeIdx;
  logic       whiteBallShow;
  logic       redBallShow;
  logic       resetGameN;
  logic       whiteBallHoleHit;
  logic       redBallHoleHit;
  logic [2:0] redBallHoleNum;
`ifdef HOLE_HIT_COUNT_EN
  logic [7:0] whiteHitCount;
  logic [7:0] redHitCount;
`endif

  typedef struct packed {
    logic       w;
    logic       r;
    logic [2:0] num;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hole_hit_detector #(
    .HOLE_COUNT    (6),
    .CONFIRM_FRAMES(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .whiteBallDR     (whiteBallDR),
    .redBallDR       (redBallDR),
    .holeDR          (holeDR),
    .holeIdx         (holeIdx),
    .whiteBallShow   (whiteBallShow),
    .redBallShow     (redBallShow),
    .resetGameN      (resetGameN),
    .whiteBallHoleHit(whiteBallHoleHit),
    .redBallHoleHit  (redBallHoleHit),
    .redBallHoleNum  (redBallHoleNum)
`ifdef HOLE_HIT_COUNT_EN
    ,
    .whiteHitCount   (whiteHitCount),
    .redHitCount     (redHitCount)
`endif
  );

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_px();
    whiteBallDR = 1'b0;
    redBallDR   = 1'b0;
    holeDR      = 1'b0;
    holeIdx     = 3'd0;
  endtask

  task automatic set_px(input logic w, input logic r, input logic [2:0] idx);
    whiteBallDR = w;
    redBallDR   = r;
    holeDR      = w | r;
    holeIdx     = idx;
  endtask

  // Drive one frame and check the evaluation made at its startOfFrame.
  task automatic drive_frame(input string name, input logic w, input logic r,
                             input logic [2:0] idx, input logic on_sof,
                             input logic ew, input logic er, input logic [2:0] en);
    exp_t e;
    logic quiet_ok;
    e.w = ew;
    e.r = er;
    e.num = en;
    sb_q.push_back(e);
    startOfFrame = 1'b1;
    if (on_sof) set_px(w, r, idx);
    else clear_px();
    step();
    startOfFrame = 1'b0;
    e = sb_q.pop_front();
    vectors++;
    if (whiteBallHoleHit !== e.w) begin
      miscompares++;
      $display("FAIL %s white_pulse: got %b expected %b", name, whiteBallHoleHit, e.w);
    end
    vectors++;
    if (redBallHoleHit !== e.r) begin
      miscompares++;
      $display("FAIL %s red_pulse: got %b expected %b", name, redBallHoleHit, e.r);
    end
    vectors++;
    if (redBallHoleNum !== e.num) begin
      miscompares++;
      $display("FAIL %s red_num: got %0d expected %0d", name, redBallHoleNum, e.num);
    end
    quiet_ok = 1'b1;
    for (int c = 1; c < 8; c++) begin
      if (!on_sof && c >= 2 && c <= 5) set_px(w, r, idx);
      else clear_px();
      step();
      if (whiteBallHoleHit !== 1'b0 || redBallHoleHit !== 1'b0) quiet_ok = 1'b0;
    end
    clear_px();
    vectors++;
    if (quiet_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL %s quiet_rest_of_frame: got extra pulse expected none", name);
    end
  endtask

  // Hide both balls for one cycle to bring both FSMs back to ARMED.
  task automatic rearm();
    whiteBallShow = 1'b0;
    redBallShow   = 1'b0;
    step();
    whiteBallShow = 1'b1;
    redBallShow   = 1'b1;
  endtask

  task automatic game_restart();
    resetGameN = 1'b0;
    step();
    resetGameN = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    startOfFrame  = 1'b0;
    whiteBallShow = 1'b1;
    redBallShow   = 1'b1;
    resetGameN    = 1'b1;
    clear_px();
    step();
    step();
    reset = 1'b0;
    vectors++;
    if (whiteBallHoleHit !== 1'b0 || redBallHoleHit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b%b expected 00", whiteBallHoleHit, redBallHoleHit);
    end
    vectors++;
    if (redBallHoleNum !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_num: got %0d expected 0", redBallHoleNum);
    end
  endtask

  task automatic test_red_confirm();
    drive_frame("confirm_f1", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0);
    drive_frame("confirm_f2", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0);
    drive_frame("confirm_f3", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3);
    drive_frame("confirm_f4", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd3);
    rearm();
  endtask

  // One overlap then a gap must drop back to ARMED: a later single overlap cannot fire.
  task automatic test_red_abort();
    drive_frame("abort_f1", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("abort_f2", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("abort_f3", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("abort_f4", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("abort_f5", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
  endtask

  task automatic test_red_reindex();
    drive_frame("reidx_f1", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("reidx_f2", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("reidx_f3", 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd3);
    drive_frame("reidx_f4", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5);
    rearm();
  endtask

  task automatic test_back_to_back();
    drive_frame("both_f1", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd5);
    drive_frame("both_f2", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd5);
    drive_frame("both_f3", 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 3'd1);
    drive_frame("both_f4", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("both_f5", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    whiteBallShow = 1'b0;
    step();
    whiteBallShow = 1'b1;
    drive_frame("both_f6", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("both_f7", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("both_f8", 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1);
    rearm();
  endtask

  task automatic test_gating();
    redBallShow = 1'b0;
    for (int f = 0; f < 5; f++)
      drive_frame("hidden_red", 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd1);
    redBallShow = 1'b1;
    drive_frame("hidden_red_after", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    for (int f = 0; f < 5; f++)
      drive_frame("bad_idx7", 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("bad_idx7_after", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1);
  endtask

  task automatic test_restart();
    drive_frame("rst_cnt_f1", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("rst_cnt_f2", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd1);
    game_restart();
    drive_frame("rst_cnt_f3", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("rst_cnt_f4", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("rst_fired_f1", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("rst_fired_f2", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd1);
    drive_frame("rst_fired_f3", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6);
    game_restart();
    drive_frame("rst_rearm_f1", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd6);
    drive_frame("rst_rearm_f2", 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd6);
    drive_frame("rst_rearm_f3", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2);
    rearm();
  endtask

  // Overlap present only in the startOfFrame cycle belongs to the new frame.
  task automatic test_frame_boundary();
    drive_frame("sof_px_f1", 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd2);
    drive_frame("sof_px_f2", 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd2);
    drive_frame("sof_px_f3", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4);
    rearm();
  endtask

  task automatic test_reset_mid();
    drive_frame("rst_mid_f1", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd4);
    drive_frame("rst_mid_f2", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd4);
    reset = 1'b1;
    step();
    vectors++;
    if (whiteBallHoleHit !== 1'b0 || redBallHoleHit !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_pulses: got %b%b expected 00", whiteBallHoleHit, redBallHoleHit);
    end
    vectors++;
    if (redBallHoleNum !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid_num: got %0d expected 0", redBallHoleNum);
    end
    reset = 1'b0;
    drive_frame("rst_mid_f3", 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0);
    drive_frame("rst_mid_f4", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    drive_frame("rst_mid_f5", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

`ifdef HOLE_HIT_COUNT_EN
  task automatic test_hit_count();
    for (int h = 0; h < 3; h++) begin
      drive_frame("count_f1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, (h == 0) ? 3'd0 : 3'd1);
      drive_frame("count_f2", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, (h == 0) ? 3'd0 : 3'd1);
      drive_frame("count_f3", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1);
      rearm();
    end
    vectors++;
    if (redHitCount !== 8'd3) begin
      miscompares++;
      $display("FAIL red_count_3: got %0d expected 3", redHitCount);
    end
    vectors++;
    if (whiteHitCount !== 8'd0) begin
      miscompares++;
      $display("FAIL white_count_0: got %0d expected 0", whiteHitCount);
    end
    game_restart();
    step();
    vectors++;
    if (redHitCount !== 8'd3) begin
      miscompares++;
      $display("FAIL red_count_after_restart: got %0d expected 3", redHitCount);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (redHitCount !== 8'd0) begin
      miscompares++;
      $display("FAIL red_count_after_reset: got %0d expected 0", redHitCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_red_confirm();
    test_red_abort();
    test_red_reindex();
    test_back_to_back();
    test_gating();
    test_restart();
    test_frame_boundary();
    test_reset_mid();
`ifdef HOLE_HIT_COUNT_EN
    test_hit_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hole_hit_detector.md
Name: hole_hit_detector

Overview:
- Producer of the ball-into-hole event interface that game_controller consumes: whiteBallHoleHit, redBallHoleHit and redBallHoleNum.
- Watches per-pixel draw requests from the ball and hole drawers during the frame scan.
- Requires overlap on CONFIRM_FRAMES consecutive frames, then emits exactly one single-cycle hit pulse per ball per sinking.
- Rearms once the controller hides the ball or restarts the game.

Parameters:
- HOLE_COUNT, 6: number of valid holes; valid holeIdx values are 1..HOLE_COUNT.
- CONFIRM_FRAMES, 2: consecutive overlapping frames needed to confirm a hit; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- startOfFrame  input  1  one-cycle pulse at the start of each frame
- whiteBallDR  input  1  white ball drawing request for the current pixel
- redBallDR  input  1  red ball drawing request for the current pixel
- holeDR  input  1  hole drawing request for the current pixel
- holeIdx  input  3  index of the hole being drawn; valid only when holeDR=1
- whiteBallShow  input  1  from controller; 0 means the white ball is hidden
- redBallShow  input  1  from controller; 0 means the red ball is hidden
- resetGameN  input  1  from controller; 0 means a rack restart
- whiteBallHoleHit  output  1  one-cycle hit pulse for the white ball
- redBallHoleHit  output  1  one-cycle hit pulse for the red ball
- redBallHoleNum  output  3  hole index of the last confirmed red hit

Behaviour:
- Reset: applies on the clk edge while reset=1.
  - Both pulses 0, redBallHoleNum=0.
  - All accumulators, counters and FSMs cleared; both FSMs go to ARMED.
- Per-frame accumulation: each cycle the accumulator collects overlaps for the current frame.
  - whiteSeen sets when whiteBallDR&holeDR and holeIdx is in 1..HOLE_COUNT.
  - redSeen sets on the same condition with redBallDR.
  - redIdx captures holeIdx on the first red overlap of the frame; later overlaps in the same frame do not overwrite it.
  - holeIdx of 0 or above HOLE_COUNT is ignored.
- Frame boundary (startOfFrame=1): evaluate the previous frame's flags, then clear the accumulators.
  - A pixel overlap in the startOfFrame cycle itself belongs to the new frame and is captured into the cleared accumulator.
- Per-ball FSM, evaluated only at startOfFrame:
  - ARMED: seen=1 goes to COUNTING with cnt=1. If CONFIRM_FRAMES=1, it goes straight to FIRE instead.
  - COUNTING: seen=0 returns to ARMED with cnt=0. seen=1 increments cnt; when cnt reaches CONFIRM_FRAMES, go to FIRE.
  - COUNTING, red ball only: if redIdx differs from the index held since counting began, cnt restarts at 1 with the new index.
  - FIRE: lasts exactly one cycle, the cycle after the startOfFrame. The ball's pulse is 1 in this cycle. For the red ball, redBallHoleNum updates in this same cycle (registered, no extra latency). Then go to FIRED.
  - FIRED: no further pulses regardless of overlap.
- Leaving FIRED: go to ARMED when the ball's Show input is 0 or resetGameN=0.
- Show gating: while a ball's Show=0, its FSM is held in ARMED and its seen flag is forced to 0, so a hidden ball never counts.
- Game restart: resetGameN=0 in any state clears cnt and forces ARMED. redBallHoleNum is kept.
- Independence: both balls may fire in the same cycle; the two FSMs are fully independent.
- Pulse latency: exactly 1 cycle after the confirming startOfFrame.
- Width rule: cnt is 4 bits and never exceeds CONFIRM_FRAMES.

Optional Feature:
- Macro: HOLE_HIT_COUNT_EN.
- When defined, two extra output ports are added:
  - whiteHitCount  output  8  saturating count of white FIRE events
  - redHitCount  output  8  saturating count of red FIRE events
  - Each count increments in the FIRE cycle and saturates at 255.
  - Cleared only by reset, not by resetGameN.
- When undefined, these ports and their counters do not exist and all other behaviour is identical.

Test Plan:
- Defaults, CONFIRM_FRAMES=2. Red overlaps hole 3 in frames 1 and 2 -> redBallHoleHit=1 for exactly one cycle, one cycle after the third startOfFrame; redBallHoleNum=3.
- Red overlaps hole 4 in frame 1 and no hole in frame 2 -> no pulse; FSM back in ARMED with cnt=0.
- Red overlaps hole 2 in frame 1, then hole 5 in frames 2 and 3 -> a single pulse after frame 3's evaluation; redBallHoleNum=5.
- White and red both overlap for 2 frames -> both pulses in the same cycle.
  - Continued overlap with Show=1 -> no further pulses.
  - whiteBallShow=0 for one cycle, then 1 with overlap again for 2 frames -> a second white pulse.
- Overlap present with redBallShow=0, and separately with holeIdx=7 -> no pulse for 5 frames in either case.
- Reset asserted in COUNTING with cnt=1 -> next cycle pulses=0, redBallHoleNum=0, FSMs in ARMED.
- With HOLE_HIT_COUNT_EN, 3 confirmed red hits -> redHitCount=3.
  - A resetGameN=0 pulse leaves it at 3; a reset pulse clears it to 0.
